// File: rtl/div_unit_pkg.sv
// Shared divider definitions: register-bus width, reset level and the state encoding.
// EX decodes div_state_e to build its stall condition, so the encoding is fixed here.
// No logic lives in this package.
package div_unit_pkg;

  localparam int          REG_BUS    = 32;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;

  // Divider sequencer states, 2-bit encoding visible to EX.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// EX <-> divider request/result bundle.
// master = EX side (drives operands and start/annul), slave = divider.
// Result fields are only meaningful while ready_o is high.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = REG_BUS
);

  logic             signed_div_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             start_i;
  logic             annul_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             ready_o;
  logic             busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  hi_o, lo_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output hi_o, lo_o, ready_o, busy_o
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
// Purely combinational, zero latency.
// No flow control; the sequencer in div_unit decides when the result is taken.
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = REG_BUS
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted remainder can reach 2*divisor-1, so the trial needs one extra bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_i};

  // Negative trial (MSB set) means the divisor did not fit: keep the shifted remainder.
  assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU; remainder -> hi_o, quotient -> lo_o.
// Latency: ready_o after WIDTH+1 edges from the start edge (2 edges on divide-by-zero).
// Backpressure: result held in END while start_i stays high; annul_i aborts from any state.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = REG_BUS,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  div_if
);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             ready_q;
  logic             busy_q;

  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             sgn1;
  logic             sgn2;

  // Operand signs only matter for DIV; DIVU treats the MSB as magnitude.
  assign sgn1 = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
  assign sgn2 = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
  assign mag1 = sgn1 ? (~div_if.opdata1_i + 1'b1) : div_if.opdata1_i;
  assign mag2 = sgn2 ? (~div_if.opdata2_i + 1'b1) : div_if.opdata2_i;

  // Sign fix-up applied once, on the cycle that leaves ON.
  assign quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  div_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Sequencer: all state and registered outputs; reset and annul both return to FREE.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || div_if.annul_i) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (div_if.start_i) begin
            busy_q <= 1'b1;
            if (div_if.opdata2_i == '0) begin
              // Divide-by-zero result is staged here and published from END.
              state_q   <= DIV_BYZERO;
              rem_q     <= div_if.opdata1_i;
              quo_q     <= '1;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              // Quotient register starts with the dividend magnitude and is shifted out.
              state_q   <= DIV_ON;
              cnt_q     <= '0;
              rem_q     <= '0;
              quo_q     <= mag1;
              dvs_q     <= mag2;
              neg_quo_q <= sgn1 ^ sgn2;
              neg_rem_q <= sgn1;
            end
          end
        end

        DIV_BYZERO: begin
          state_q <= DIV_END;
          busy_q  <= 1'b0;
        end

        DIV_ON: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q <= DIV_END;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            hi_q    <= rem_fix;
            lo_q    <= quo_fix;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DIV_END: begin
          if (!ready_q) begin
            // Arrived from BYZERO: publish the staged result.
            ready_q <= 1'b1;
            hi_q    <= rem_q;
            lo_q    <= quo_q;
          end else if (!div_if.start_i) begin
            state_q <= DIV_FREE;
            ready_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
          end
        end

        default: begin
          state_q <= DIV_FREE;
        end
      endcase
    end
  end

  assign div_if.hi_o    = hi_q;
  assign div_if.lo_o    = lo_q;
  assign div_if.ready_o = ready_q;
  assign div_if.busy_o  = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected {hi,lo} plus latency/busy checks.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every wait on the DUT is bounded.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(W)) dif ();

  div_unit #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, wait for ready, compare against the scoreboard, then release.
  // corrupt=1 scribbles over the operands a few cycles into the operation.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat,
                        input int exp_busy, input bit corrupt);
    int lat;
    int busy_n;
    logic [63:0] e;
    exp_q.push_back({exp_hi, exp_lo});
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    @(posedge clk); #1;
    lat    = 0;
    busy_n = 0;
    while (!dif.ready_o && lat < 100) begin
      if (dif.busy_o) busy_n++;
      if (corrupt && lat == 3) begin
        dif.opdata1_i    = 32'hDEAD_BEEF;
        dif.opdata2_i    = 32'h0;
        dif.signed_div_i = ~sgn;
      end
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_val({tag, " hi"}, {32'h0, dif.hi_o}, {32'h0, e[63:32]});
    check_val({tag, " lo"}, {32'h0, dif.lo_o}, {32'h0, e[31:0]});
    // Result must hold while start stays high.
    @(posedge clk); #1;
    check_val({tag, " hold"}, {dif.ready_o, dif.hi_o, dif.lo_o}, {1'b1, e});
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check_val({tag, " release"}, {dif.ready_o, dif.busy_o, dif.hi_o, dif.lo_o}, '0);
  endtask

  initial begin
    bit seen_ready;
    logic        rs;
    logic [31:0] ra, rb;
    logic signed [31:0] sa, sb;
    logic [31:0] qh, ql;

    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset outputs", {dif.ready_o, dif.busy_o, dif.hi_o, dif.lo_o}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("divu 100/7",   1'b0, 32'd100,       32'd7,         32'h2,        32'hE,        33, 33, 1'b0);
    run_op("div -7/2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, 1'b0);
    run_op("div 7/-2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'h1,        32'hFFFF_FFFD, 33, 33, 1'b0);
    run_op("divu 5/0",     1'b0, 32'd5,         32'd0,         32'h5,        32'hFFFF_FFFF, 2,  1,  1'b0);
    run_op("div ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 33, 33, 1'b0);
    run_op("divu max/1",   1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,        32'hFFFF_FFFF, 33, 33, 1'b0);

    // Annul at iteration 10: back to FREE, no result ever appears.
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd100;
    dif.opdata2_i    = 32'd7;
    dif.start_i      = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    dif.annul_i = 1'b0;
    check_val("annul outputs", {dif.ready_o, dif.busy_o, dif.hi_o, dif.lo_o}, '0);
    seen_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (dif.ready_o || dif.busy_o) seen_ready = 1'b1;
    end
    check_val("annul no ready", 64'(seen_ready), 64'h0);
    run_op("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'h0, 32'h3, 33, 33, 1'b0);

    // Synchronous reset in the middle of ON discards everything.
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd10;
    dif.start_i   = 1'b1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rst         = 1'b1;
    dif.start_i = 1'b0;
    @(posedge clk); #1;
    check_val("mid-op reset", {dif.ready_o, dif.busy_o, dif.hi_o, dif.lo_o}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Operands are latched at start; later changes must not matter.
    run_op("latched ops", 1'b0, 32'd1000, 32'd7, 32'd6, 32'd142, 33, 33, 1'b1);

    // Random operands against a behavioural reference.
    for (int i = 0; i < 6; i++) begin
      rs = 1'(i % 2);
      ra = $urandom;
      rb = $urandom;
      if (i >= 4) rb = rb >> 20;
      if (rb == 32'h0) rb = 32'd3;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd5;
      sa = ra;
      sb = rb;
      if (rs) begin
        ql = sa / sb;
        qh = sa % sb;
      end else begin
        ql = ra / rb;
        qh = ra % rb;
      end
      run_op($sformatf("rand%0d", i), rs, ra, rb, qh, ql, 33, 33, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for DIV/DIVU; one quotient bit per cycle, restoring algorithm.
- Drives the HI/LO write side: remainder goes to HI, quotient goes to LO.
- Sits beside EX. EX holds start_i and stalls the pipeline until ready_o. The result then passes down the pipeline to the HI/LO register write port.

Parameters:
- WIDTH, 32, operand/result width; equals `RegBus width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable).
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request. Level-held by EX until it has consumed the result.
- annul_i  in  1  flush/exception cancel. Aborts any operation.
- hi_o  out  WIDTH  remainder. Valid only while ready_o=1.
- lo_o  out  WIDTH  quotient. Valid only while ready_o=1.
- ready_o  out  1  result valid.
- busy_o  out  1  division in progress (states BYZERO or ON).

Behaviour:
- State machine: FREE, BYZERO, ON, END.
- Reset (rst=1 on an edge):
  - state=FREE, counter=0.
  - hi_o=lo_o=`ZeroWord; ready_o=0; busy_o=0.
  - Reset mid-operation discards all state.
- annul_i=1 in any state: next state FREE, outputs as reset. annul_i has priority over start_i.
- FREE:
  - On start_i=1, annul_i=0: latch signed_div_i, opdata1_i, opdata2_i.
    - If divisor=0, go to BYZERO.
    - Otherwise compute the operand magnitudes (two's-complement abs when signed and the MSB is set), load the partial remainder=0 and counter=0, and go to ON.
  - Operand changes after latching are ignored.
- BYZERO: one cycle, then END with hi=dividend unchanged and lo={WIDTH{1}}.
- ON:
  - Each cycle: shift {rem,quo} left by 1, trial-subtract the divisor magnitude, set the quotient bit if the result is non-negative. Counter increments.
  - After WIDTH iterations, go to END.
  - Final fix-up, signed only:
    - Negate the quotient if the dividend and divisor signs differ.
    - Negate the remainder if the dividend is negative.
- END: ready_o=1; hi_o/lo_o hold the result.
  - Stay in END while start_i=1.
  - When start_i=0, go to FREE; ready_o=0 and outputs return to zero on the next cycle.
- Latency:
  - Start sampled at edge N. ready_o=1 after edge N+WIDTH+1 (33 cycles for WIDTH=32).
  - Divide-by-zero: ready_o=1 after edge N+2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- Back-to-back operations: a new start is accepted only in FREE. start_i must drop for at least one cycle between operations.
- busy_o=1 exactly in BYZERO and ON.

Decomposition:
- Shared package / define.vh: `RegBus, `ZeroWord, `RstEnable, and the div state encoding (DivFree, DivByZero, DivOn, DivEnd, 2 bits), so the EX stall logic can decode them.
- Optional sub-module div_step: combinational one-iteration shift/subtract. Keeps the sequencer readable; all sequential logic stays in div_unit.

Test Plan:
- DIVU 100 / 7, start held → ready_o=1 exactly 33 cycles after start; lo=0x0000000E, hi=0x00000002. After start_i drops, ready_o=0 next cycle.
- DIV -7 (0xFFFFFFF9) / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7 / -2 → lo=0xFFFFFFFD, hi=0x00000001.
- DIVU 5 / 0 → ready_o=1 two cycles after start; hi=0x00000005, lo=0xFFFFFFFF; busy_o=1 for one cycle.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- annul_i pulsed at iteration 10 → FREE next cycle, ready_o never asserts. New start of 9/3 → lo=3, hi=0 after 33 cycles.
- rst asserted mid-ON → all outputs zero next cycle. Operand changes during ON do not alter the result.
